// File: rtl/memoria_slots_aste.sv
// Parametrised slot memory for game objects: sequenced clear sweep, hardware occupancy
// tracking, lowest-free-slot lookup, occupied count and full flag.
module memoria_slots_aste #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic [ADDR_W-1:0] free_addr,
    output logic              free_valid,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    // state | meaning
    // IDLE  | normal operation: reads, writes, free-slot tracking
    // CLR   | clear sweep, zeroing one entry per edge, busy high
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, CLR} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DEPTH-1:0]  occ, occ_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] free_addr_next;
    logic [ADDR_W:0]   count_next;
    logic              wr_en;
    logic              free_any;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        occ_next   = occ;
        count_next = count;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = CLR;
                    ptr_next   = '0;
                    occ_next   = '0;
                    count_next = '0;
                end else if (we) begin
                    wr_en          = 1'b1;
                    occ_next[addr] = (data != '0);
                    if ((data != '0) && !occ[addr])
                        count_next = count + 1'b1;
                    else if ((data == '0) && occ[addr])
                        count_next = count - 1'b1;
                end
            end
            CLR: begin
                if (clear) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                    if (&ptr)
                        state_next = IDLE;
                end
            end
            default: state_next = CLR;
        endcase
    end

    // Lowest-index free slot of the post-edge occupancy; holds when nothing is free.
    always_comb begin
        free_any       = ~&occ_next;
        free_addr_next = free_addr;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!occ_next[i])
                free_addr_next = ADDR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLR;
            ptr        <= '0;
            occ        <= '0;
            count      <= '0;
            full       <= 1'b0;
            addr_reg   <= '0;
            free_addr  <= '0;
            free_valid <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            occ        <= occ_next;
            count      <= count_next;
            full       <= (count_next == DEPTH_CNT);
            if (state == IDLE)
                addr_reg <= addr;
            free_addr  <= free_addr_next;
            free_valid <= free_any && (state_next == IDLE);
        end
    end

    // Array deliberately has no reset; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[addr] <= data;
        else if ((state == CLR) && !clear)
            ram[ptr] <= '0;
    end

    assign busy = (state == CLR);
    assign q    = busy ? '0 : ram[addr_reg];

    assert property (@(posedge clk) disable iff (!reset_n) int'(count) == $countones(occ));

endmodule

// File: tb/tb_memoria_slots_aste.sv
// Bench for memoria_slots_aste: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against an array-based slot model.
module tb_memoria_slots_aste;
    localparam int DW    = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] q;
    logic          busy;
    logic [AW-1:0] free_addr;
    logic          free_valid;
    logic [AW:0]   count;
    logic          full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memoria_slots_aste #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .we         (we),
        .addr       (addr),
        .data       (data),
        .q          (q),
        .busy       (busy),
        .free_addr  (free_addr),
        .free_valid (free_valid),
        .count      (count),
        .full       (full)
    );

    // Slot model: contents as plain ints, sweep as a remaining-edge counter.
    int m_mem [DEPTH];
    int m_left = DEPTH;
    int m_areg = 0;
    int m_fa   = 0;
    bit m_fv   = 1'b0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (m_mem[i] != 0) n++;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_left = DEPTH;
            m_areg = 0;
            m_fa   = 0;
            m_fv   = 1'b0;
        end else begin
            if (m_left > 0) begin
                m_left = clear ? DEPTH : m_left - 1;
            end else begin
                m_areg = int'(addr);
                if (clear) begin
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
                    m_left = DEPTH;
                end else if (we) begin
                    m_mem[addr] = int'(data);
                end
            end
            m_fv = 1'b0;
            for (int i = DEPTH-1; i >= 0; i--) begin
                if (m_mem[i] == 0) begin
                    m_fa = i;
                    m_fv = (m_left == 0);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit eb;
        eb = (m_left > 0);
        check("busy", int'(busy), int'(eb));
        check("q", int'(q), eb ? 0 : m_mem[m_areg]);
        check("count", int'(count), m_count());
        check("full", int'(full), int'(m_count() == DEPTH));
        check("free_valid", int'(free_valid), int'(m_fv));
        check("free_addr", int'(free_addr), m_fa);
    end

    // Apply inputs at the current falling edge, return at the next one.
    task automatic step(input bit w, input int a, input int d, input bit c);
        we    = w;
        addr  = a[AW-1:0];
        data  = d[DW-1:0];
        clear = c;
        @(negedge clk);
    endtask

    task automatic expect_sweep(input string name);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 0, 0, 1'b0);
            check(name, int'(busy), int'(i < DEPTH));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            check("rel_busy", int'(busy), int'(i < DEPTH));
        end
        check("rel_count", int'(count), 0);
        check("rel_fv", int'(free_valid), 1);
        check("rel_fa", int'(free_addr), 0);
        check("rel_q", int'(q), 0);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, a, 0, 1'b0);
            check("rel_rd", int'(q), 0);
        end

        step(1'b1, 3, 2, 1'b0);
        check("wr3_q", int'(q), 2);
        check("wr3_count", int'(count), 1);
        check("wr3_fa", int'(free_addr), 0);
        step(1'b0, 3, 0, 1'b0);
        check("rd3_q", int'(q), 2);

        for (int i = 0; i < DEPTH; i++) step(1'b1, i, 1, 1'b0);
        check("fill_count", int'(count), 16);
        check("fill_full", int'(full), 1);
        check("fill_fv", int'(free_valid), 0);
        check("fill_fa_hold", int'(free_addr), 15);
        step(1'b1, 9, 0, 1'b0);
        check("free9_count", int'(count), 15);
        check("free9_full", int'(full), 0);
        check("free9_fv", int'(free_valid), 1);
        check("free9_fa", int'(free_addr), 9);

        step(1'b1, 5, 3, 1'b0);
        check("ovw5_count", int'(count), 15);
        check("ovw5_q", int'(q), 3);
        step(1'b1, 5, 0, 1'b0);
        check("zero5a_count", int'(count), 14);
        step(1'b1, 5, 0, 1'b0);
        check("zero5b_count", int'(count), 14);

        step(1'b0, 0, 0, 1'b1);
        repeat (DEPTH) step(1'b0, 0, 0, 1'b0);
        check("clr1_busy", int'(busy), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 2*i + 1, 2, 1'b0);
        check("six_count", int'(count), 6);
        step(1'b1, 2, 3, 1'b1);
        check("clrwe_count", int'(count), 0);
        check("clrwe_busy", int'(busy), 1);
        check("clrwe_q", int'(q), 0);
        expect_sweep("clrwe_sweep");
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, a, 0, 1'b0);
            check("clrwe_rd", int'(q), 0);
        end

        step(1'b1, 4, 1, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        repeat (7) step(1'b0, 0, 0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 1);
        check("rst_mid_count", int'(count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_sweep("rst_mid_sweep");

        step(1'b0, 0, 0, 1'b1);
        repeat (10) step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        expect_sweep("clr_mid_sweep");

        for (int n = 0; n < 1500; n++) begin
            int ph;
            int d;
            bit c;
            ph = (n / 250) % 2;
            if ($urandom_range(0, 999) < 5) begin
                reset_n = 1'b0;
                step(1'b0, 0, 0, 1'b0);
                reset_n = 1'b1;
                continue;
            end
            c = ($urandom_range(0, 999) < (ph == 0 ? 3 : 15));
            if (ph == 0) d = int'($urandom_range(1, 3));
            else         d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
            step($urandom_range(0, 99) < 70, int'($urandom_range(0, DEPTH-1)), d, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memoria_slots_aste.md
Name: memoria_slots_aste

Overview:
Parametrised slot memory for game-object state (asteroids, shots). It is the successor of the fixed 16x2 load memory: width and depth are generic, clear is a sequenced sweep with a busy flag, and occupancy is tracked in hardware. The block reports the first free slot, the occupied-slot count and a full flag, so the spawn logic can allocate without scanning the RAM itself. It sits between the game controller FSM and the object renderer/collision logic.

Parameters:
DATA_W, 2, bits per entry; value 0 means the slot is free, any nonzero value means occupied.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.

Ports:
clk  in  1  system clock, all state changes on the rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous request to start a clear sweep (single-cycle pulse or level)
we  in  1  write enable
addr  in  ADDR_W  read/write address
data  in  DATA_W  write data
q  out  DATA_W  registered-address read data
busy  out  1  high while a clear sweep runs
free_addr  out  ADDR_W  lowest-index free slot (registered)
free_valid  out  1  free_addr is meaningful (at least one free slot exists and busy is low)
count  out  ADDR_W+1  number of occupied slots
full  out  1  count == DEPTH

Behaviour:
- Storage: RAM array DEPTH x DATA_W with no reset on the array. Occupancy vector occ[DEPTH-1:0] is held in flops. addr_reg is a flop.
- Reset (reset_n low, asynchronous): FSM enters CLR, ptr=0, occ=0, count=0, addr_reg=0, free_addr=0, free_valid=0. busy=1, q=0, full=0 while in reset and throughout the sweep.
- FSM states: IDLE and CLR.
  - CLR: each edge writes ram[ptr]<=0 and increments ptr.
  - The edge with ptr==DEPTH-1 transitions to IDLE. The sweep therefore lasts DEPTH edges.
  - After reset release, busy drops after exactly DEPTH rising edges.
- IDLE with clear=1 at an edge: enter CLR with ptr=0. occ=0 and count=0 at that same edge. busy=1 from the next cycle, for DEPTH cycles.
- clear=1 during CLR: ptr restarts at 0 and the sweep is extended.
- Writes (IDLE only, clear=0, we=1): ram[addr]<=data and occ[addr]<=(data!=0).
  - count updates at the same edge: +1 for free->occupied, -1 for occupied->free, unchanged otherwise.
  - A write of a nonzero value over a nonzero entry leaves count unchanged.
- Ignored writes: any write with clear=1 (clear wins) or while busy=1 is dropped with no state change.
- Read:
  - addr_reg<=addr on every edge in IDLE. q = ram[addr_reg] in IDLE.
  - Latency is 1 cycle, write-first: a write and a read of the same address at edge E return the new data after E.
  - While busy=1, q is forced to 0.
- Free slot: each edge, free_addr<=lowest index i with occ_next[i]==0, where occ_next is the value after the current edge's update.
  - free_valid<=(occ_next not all ones) and next state is IDLE.
  - If all slots are full, free_valid=0 and free_addr holds its previous value.
- full = (count==DEPTH), registered together with count.
- Invariant: count equals the popcount of occ at all times; assertions check this.

Test Plan:
- Reset release with DEPTH=16 -> busy=1 for 16 edges then 0; q=0, count=0, free_valid=1, free_addr=0 after busy falls; every address reads 0.
- Write addr=3 data=2'b10, then read addr=3 -> q=2'b10 one cycle after addr is registered; count=1; free_addr stays 0.
- Fill addresses 0..15 with 2'b01 -> count=16, full=1, free_valid=0. Then write addr=9 data=0 -> count=15, full=0, free_valid=1, free_addr=9.
- Overwrite occupied addr=5 (2'b01->2'b11) -> count unchanged. Write addr=5 data=0 twice -> count decrements once only.
- With 6 slots occupied, pulse clear together with we (addr=2, data=2'b11) -> write dropped; count=0 at that edge; busy=1 for 16 cycles with q=0; afterwards all reads return 0.
- Mid-sweep events: drive reset_n low at sweep cycle 7 -> immediate busy=1, count=0, then a full 16-cycle sweep. Separately, assert clear at sweep cycle 10 -> ptr restarts and busy lasts 16 more cycles.
